// File: rtl/aes_stream_loader.sv
// aes_stream_loader: byte-stream front end for the AES core.
// Collects a command byte, a 16-byte key and a 16-byte block, pulses the core
// reset, runs the core until its done flag rises (or a timeout expires), then
// returns the 128-bit result as 16 bytes, most significant byte first.
// Optional build macro: LOADER_KEY_REUSE_EN (cmd[1]=1 skips key load, reusing aes_key).
module aes_stream_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 4000,
  parameter int unsigned TO_W           = 12
) (
  input  logic         clock,
  input  logic         resetModule,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] aes_key,
  output logic [127:0] aes_data,
  output logic         aes_ed,
  output logic         aes_enable,
  output logic         aes_reset,
  input  logic [127:0] aes_result,
  input  logic         aes_done,
  output logic         busy,
  output logic         timeout_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KEY  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ARM  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_SEND = 3'd5;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]      state;
  logic [3:0]      cnt;
  logic [TO_W-1:0] to_cnt;
  logic            done_q;
  logic [127:0]    shift;
  logic            in_xfer;
  logic            out_xfer;
  logic            done_edge;

  // Handshake and core-control outputs decoded from the current state
  always_comb begin
    in_ready   = (state == S_IDLE) || (state == S_KEY) || (state == S_DATA);
    out_valid  = (state == S_SEND);
    out_byte   = out_valid ? shift[127:120] : '0;
    busy       = (state != S_IDLE);
    aes_reset  = (state == S_ARM);
    aes_enable = (state == S_RUN) || (state == S_SEND);
    in_xfer    = in_valid && in_ready;
    out_xfer   = out_valid && out_ready;
    done_edge  = aes_done && !done_q;
  end

  // Previous value of the core done level, for 0->1 edge detection
  always_ff @(posedge clock or posedge resetModule) begin
    if (resetModule) done_q <= 1'b0;
    else             done_q <= aes_done;
  end

  // Main sequencer: load key/data, arm and run the core, stream the result
  always_ff @(posedge clock or posedge resetModule) begin
    if (resetModule) begin
      state       <= S_IDLE;
      cnt         <= '0;
      to_cnt      <= '0;
      shift       <= '0;
      aes_key     <= '0;
      aes_data    <= '0;
      aes_ed      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_xfer) begin
            aes_ed      <= in_byte[0];
            timeout_err <= 1'b0;
            cnt         <= '0;
`ifdef LOADER_KEY_REUSE_EN
            state       <= in_byte[1] ? S_DATA : S_KEY;
`else
            state       <= S_KEY;
`endif
          end
        end
        S_KEY: begin
          if (in_xfer) begin
            aes_key <= {aes_key[119:0], in_byte};
            cnt     <= cnt + 4'd1;
            if (cnt == 4'd15) state <= S_DATA;
          end
        end
        S_DATA: begin
          if (in_xfer) begin
            aes_data <= {aes_data[119:0], in_byte};
            cnt      <= cnt + 4'd1;
            if (cnt == 4'd15) state <= S_ARM;
          end
        end
        S_ARM: begin
          to_cnt <= '0;
          state  <= S_RUN;
        end
        S_RUN: begin
          // A done edge in the final timeout cycle still counts as completion
          if (done_edge) begin
            shift <= aes_result;
            cnt   <= '0;
            state <= S_SEND;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_SEND: begin
          if (out_xfer) begin
            shift <= {shift[119:0], 8'h00};
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd15) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_loader.sv
// Self-checking bench for aes_stream_loader with a behavioural AES core stand-in.
module tb_aes_stream_loader;

  localparam int TMO = 4000;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clock = 1'b0;
  logic         resetModule = 1'b0;
  logic [7:0]   in_byte = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] aes_key;
  logic [127:0] aes_data;
  logic         aes_ed;
  logic         aes_enable;
  logic         aes_reset;
  logic [127:0] aes_result;
  logic         aes_done;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  aes_stream_loader #(.TIMEOUT_CYCLES(TMO), .TO_W(12)) dut (
    .clock(clock), .resetModule(resetModule),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .aes_key(aes_key), .aes_data(aes_data), .aes_ed(aes_ed),
    .aes_enable(aes_enable), .aes_reset(aes_reset),
    .aes_result(aes_result), .aes_done(aes_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Core stand-in: known FIPS-197 pair, otherwise a simple keyed mixing
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d, input logic e);
    if (e && k == K0 && d == P0) return C0;
    if (!e && k == K0 && d == C0) return P0;
    if (e) return {d[119:0], d[127:120]} ^ k;
    return ~(d ^ k);
  endfunction

  // Behavioural core: captures operands on aes_reset, raises done after core_lat enabled cycles
  int           core_lat = 0;
  bit           core_hang = 1'b0;
  int           lat_cnt;
  logic [127:0] ck, cd;
  logic         ce;
  always @(posedge clock or posedge resetModule) begin
    if (resetModule) begin
      aes_done <= 1'b0; aes_result <= '0; lat_cnt <= 0; ck <= '0; cd <= '0; ce <= 1'b0;
    end else if (aes_reset) begin
      aes_done <= 1'b0; lat_cnt <= core_lat; ck <= aes_key; cd <= aes_data; ce <= aes_ed;
    end else if (aes_enable && !aes_done && !core_hang) begin
      if (lat_cnt == 0) begin
        aes_done <= 1'b1; aes_result <= core_fn(ck, cd, ce);
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  logic [127:0] mkey = '0;  // key the loader should currently hold

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rpat(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return c[0];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    ok = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    in_byte = b; in_valid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clock); ok = in_ready;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL in_accept: in_ready stayed 0 for 100 cycles, expected 1");
    end
  endtask

  task automatic send_block(input logic [127:0] v, input bit gaps);
    for (int i = 0; i < 16; i++) send_byte(v[127-8*i -: 8], gaps);
  endtask

  task automatic collect(input logic [127:0] data, input logic ed, input logic [127:0] exp, input int rmode);
    int n, nres;
    logic pv, pr;
    logic [7:0] pb;
    n = 0; nres = 0; pv = 1'b0; pr = 1'b0; pb = '0;
    for (int c = 0; c < 6000 && n < 16; c++) begin
      out_ready = rpat(rmode, c);
      @(negedge clock);
      if (aes_reset) begin
        nres++;
        chk("arm_key", aes_key, mkey);
        chk("arm_data", aes_data, data);
        chk("arm_ed", aes_ed, ed);
        chk("arm_enable_low", aes_enable, 0);
      end
      if (pv && !pr) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_byte", out_byte, pb);
      end
      pv = out_valid; pr = out_ready; pb = out_byte;
      if (out_valid && out_ready) begin
        chk($sformatf("out_byte%0d", n), out_byte, exp[127-8*n -: 8]);
        n++;
      end
      @(posedge clock); #1;
    end
    out_ready = 1'b0;
    chk("out_count", n, 16);
    chk("reset_pulses", nres, 1);
    @(negedge clock);
    chk("end_busy", busy, 0);
    chk("end_out_valid", out_valid, 0);
    chk("end_enable", aes_enable, 0);
    chk("end_timeout_err", timeout_err, 0);
    chk("end_in_ready", in_ready, 1);
    @(posedge clock); #1;
  endtask

  task automatic run_op(input logic [7:0] cmd, input logic [127:0] key, input logic [127:0] data,
                        input bit send_key, input logic [127:0] exp, input int rmode,
                        input int lat, input bit gaps);
    core_lat = lat;
    send_byte(cmd, gaps);
    if (send_key) begin
      send_block(key, gaps);
      mkey = key;
    end
    send_block(data, gaps);
    collect(data, cmd[0], exp, rmode);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_byte"}, out_byte, 0);
    chk({tag, "_aes_key"}, aes_key, 0);
    chk({tag, "_aes_data"}, aes_data, 0);
    chk({tag, "_aes_ed"}, aes_ed, 0);
    chk({tag, "_aes_enable"}, aes_enable, 0);
    chk({tag, "_aes_reset"}, aes_reset, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  typedef struct {
    logic [7:0]   cmd;
    logic [127:0] key;
    logic [127:0] data;
    logic [127:0] exp;
    int           rmode;
    int           lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int en, nres;
    bit sawv, fin, sk;
    logic [7:0] cmd;
    logic [127:0] key, data, ek;

    tbl[0] = '{8'h01, K0, P0, C0, 0, 5};
    tbl[1] = '{8'h00, K0, C0, P0, 0, 0};
    tbl[2] = '{8'h01, K0, P0, C0, 1, 7};
    tbl[3] = '{8'hFD, 128'h0, P0, 128'h112233445566778899aabbccddeeff00, 2, 2};
    tbl[4] = '{8'h80, 128'h0, 128'h0123456789abcdeffedcba9876543210,
               128'hfedcba98765432100123456789abcdef, 1, 1};
    tbl[5] = '{8'h01, K0, P0, C0, 2, TMO - 2};  // done edge lands in the last allowed cycle

    // Power-on reset
    #1 resetModule = 1'b1;
    @(negedge clock);
    chk_reset_values("por");
    @(posedge clock); #1 resetModule = 1'b0;

    // Reset in the middle of the key phase
    send_byte(8'h01, 0);
    for (int i = 0; i < 5; i++) send_byte(K0[127-8*i -: 8], 0);
    #2 resetModule = 1'b1;
    #1 chk_reset_values("mid_key");
    @(posedge clock); #1 resetModule = 1'b0;
    mkey = '0;

    // Table-driven operations
    for (int i = 0; i < 6; i++)
      run_op(tbl[i].cmd, tbl[i].key, tbl[i].data, 1'b1, tbl[i].exp, tbl[i].rmode, tbl[i].lat, 1'b0);

    // Key reuse behaviour of command bit 1
    run_op(8'h01, K0, P0, 1'b1, C0, 0, 4, 1'b0);
`ifdef LOADER_KEY_REUSE_EN
    run_op(8'h03, 128'h0, P0, 1'b0, C0, 0, 4, 1'b0);
`else
    core_lat = 4;
    send_byte(8'h03, 0);
    send_block(K0, 0);
    @(negedge clock);
    chk("k3_in_ready", in_ready, 1);
    chk("k3_busy", busy, 1);
    chk("k3_no_arm", aes_reset, 0);
    @(posedge clock); #1;
    mkey = K0;
    send_block(P0, 0);
    collect(P0, 1'b1, C0, 0);
`endif

    // Timeout: core never completes
    core_hang = 1'b1;
    send_byte(8'h01, 0);
    send_block(K0, 0);
    mkey = K0;
    send_block(P0, 0);
    en = 0; nres = 0; sawv = 1'b0; fin = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clock);
      if (out_valid) sawv = 1'b1;
      if (aes_enable) en++;
      if (aes_reset) nres++;
      if (!busy) begin fin = 1'b1; break; end
      @(posedge clock); #1;
    end
    chk("to_returned_idle", fin, 1);
    chk("to_enable_cycles", en, TMO);
    chk("to_err", timeout_err, 1);
    chk("to_in_ready", in_ready, 1);
    chk("to_no_output", sawv, 0);
    chk("to_reset_pulses", nres, 1);
    @(posedge clock); #1;
    repeat (3) begin @(posedge clock); #1; end
    @(negedge clock);
    chk("to_sticky", timeout_err, 1);
    @(posedge clock); #1;
    core_hang = 1'b0;
    core_lat = 2;
    send_byte(8'h00, 0);
    @(negedge clock);
    chk("to_cleared", timeout_err, 0);
    @(posedge clock); #1;
    send_block(K0, 0);
    send_block(C0, 0);
    collect(C0, 1'b0, P0, 0);

    // Randomised operations against the reference model
    for (int r = 0; r < 12; r++) begin
      cmd  = 8'($urandom);
      key  = {$urandom, $urandom, $urandom, $urandom};
      data = {$urandom, $urandom, $urandom, $urandom};
`ifdef LOADER_KEY_REUSE_EN
      sk = !cmd[1];
`else
      sk = 1'b1;
`endif
      ek = sk ? key : mkey;
      run_op(cmd, key, data, sk, core_fn(ek, data, cmd[0]), 2, $urandom_range(0, 20), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
